opamp_bank_seq: RTL and testbench
=================================

OPAMP_BANK_SEQ -- requirements
Module: opamp_bank_seq

Interface
REQ-001 Parameter N_CH, default 4: number of op-amp channels controlled (1..8).
REQ-002 Parameter BIAS_SETTLE, default 64: bias settle time in clk cycles (>=1, < 2**CNT_W).
REQ-003 Parameter CH_SETTLE, default 16: per-channel settle time in clk cycles (>=1, < 2**CNT_W).
REQ-004 Parameter CNT_W, default 8: settle counter width.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 ena  in  1  design enable; low forces shutdown and blocks start.
REQ-008 cfg_mask  in  N_CH  channels to power up; latched on accepted start.
REQ-009 mode  in  1  0 = staggered ramp, 1 = simultaneous ramp; latched on accepted start.
REQ-010 start  in  1  power-up request, level-sampled.
REQ-011 stop  in  1  power-down request, level-sampled.
REQ-012 bias_en  out  1  enable for shared bias generator.
REQ-013 ch_en  out  N_CH  per-channel op-amp enable.
REQ-014 ready  out  1  high only in ON.
REQ-015 busy  out  1  high in BIAS_WAIT, CH_RAMP, SHUTDOWN.
REQ-016 state  out  3  encoding OFF=0, BIAS_WAIT=1, CH_RAMP=2, ON=3, SHUTDOWN=4.

Function
REQ-017 All outputs SHALL be registered; the transition edge and the output change SHALL coincide.
REQ-018 OFF: start=1, ena=1, stop=0, cfg_mask!=0 at edge k -> latch mask_r/mode_r, bias_en=1, enter BIAS_WAIT, counter=BIAS_SETTLE-1; start with cfg_mask=0 ignored.
REQ-019 BIAS_WAIT: counter decrements each edge; edge on which counter==0 enters CH_RAMP (edge k+BIAS_SETTLE).
REQ-020 Staggered: entering CH_RAMP sets ch_en of lowest set bit of mask_r, counter=CH_SETTLE-1; each counter expiry sets next higher set bit (unset bits skipped with zero cycles) and reloads; expiry after last set bit enters ON.
REQ-021 Staggered timing: r-th set channel (r=0..M-1, M=popcount(mask_r)) enabled at edge k+BIAS_SETTLE+r*CH_SETTLE; ON at k+BIAS_SETTLE+M*CH_SETTLE.
REQ-022 Simultaneous: ch_en=mask_r at edge k+BIAS_SETTLE; ON at k+BIAS_SETTLE+CH_SETTLE.
REQ-023 ON: bias_en=1, ch_en=mask_r, ready=1, busy=0; holds until stop or ena=0.
REQ-024 stop=1 or ena=0 at edge s in BIAS_WAIT, CH_RAMP or ON -> ch_en=0, ready=0, enter SHUTDOWN, counter=CH_SETTLE-1, bias_en stays 1.
REQ-025 SHUTDOWN: counter expiry (edge s+CH_SETTLE) -> bias_en=0, enter OFF; start and stop ignored while in SHUTDOWN.
REQ-026 stop has priority over start on the same edge; start outside OFF ignored.
REQ-027 cfg_mask/mode changes after latch SHALL NOT affect ch_en until next accepted start.
REQ-028 ch_en bits outside mask_r SHALL never assert.

Reset
REQ-029 rst_n=0 at any edge, any state -> next-edge values: state=OFF, bias_en=0, ch_en=0, ready=0, busy=0, counter=0, mask_r=0, mode_r=0; no shutdown delay.
REQ-030 rst_n overrides all inputs; first start accepted on first edge with rst_n=1.

Verification (defaults N_CH=4, BIAS_SETTLE=64, CH_SETTLE=16)
REQ-031 mask=4'b1011, mode=0, start at edge 0 -> bias_en at 0; ch_en=0001@64, 0011@80, 1011@96; ready@112; busy 0..111.
REQ-032 mask=4'b1011, mode=1, start at edge 0 -> ch_en=1011@64, ready@80.
REQ-033 From ON, stop at edge s -> ch_en=0000, ready=0, state=4 @s; bias_en=0, state=0 @s+16; start during s..s+15 ignored.
REQ-034 start with cfg_mask=0 -> state stays 0, all outputs 0; start+stop same edge in OFF -> stays OFF.
REQ-035 rst_n=0 at edge 70 of REQ-031 run -> all outputs 0, state=0 @70; ena=0 in ON -> identical to REQ-033.

Source files
------------

// File: rtl/opamp_bank_seq.sv
// Power sequencer for a bank of op-amp channels sharing one bias generator.
// Brings up the bias first, then ramps channels (staggered or all at once).
// Shuts down channels before the bias. Every output comes from a flop, so
// each output changes on the same edge as the state transition that causes it.
module opamp_bank_seq #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned BIAS_SETTLE = 64,
    parameter int unsigned CH_SETTLE   = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [N_CH-1:0] cfg_mask,
    input  logic            mode,
    input  logic            start,
    input  logic            stop,
    output logic            bias_en,
    output logic [N_CH-1:0] ch_en,
    output logic            ready,
    output logic            busy,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        StOff      = 3'd0,
        StBiasWait = 3'd1,
        StChRamp   = 3'd2,
        StOn       = 3'd3,
        StShutdown = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] BiasLoad = CNT_W'(BIAS_SETTLE - 1);
    localparam logic [CNT_W-1:0] ChLoad   = CNT_W'(CH_SETTLE - 1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic              mode_q, mode_d;
    logic              bias_q, bias_d;
    logic [N_CH-1:0]   ch_q, ch_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [N_CH-1:0]   remaining;
    logic              abort;

    // One-hot of the lowest set bit of v (zero if v is zero).
    function automatic logic [N_CH-1:0] lowest_bit(input logic [N_CH-1:0] v);
        logic [N_CH-1:0] r;
        logic            found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Next-state and next-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        mode_d    = mode_q;
        bias_d    = bias_q;
        ch_d      = ch_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        // Latched channels not yet enabled; the ramp walks these low to high.
        remaining = mask_q & ~ch_q;
        abort     = stop || !ena;

        unique case (state_q)
            StOff: begin
                if (ena && start && !stop && (cfg_mask != '0)) begin
                    state_d = StBiasWait;
                    cnt_d   = BiasLoad;
                    mask_d  = cfg_mask;
                    mode_d  = mode;
                    bias_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            StBiasWait, StChRamp, StOn: begin
                if (abort) begin
                    // Channels drop immediately; bias holds while they discharge.
                    state_d = StShutdown;
                    cnt_d   = ChLoad;
                    ch_d    = '0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    bias_d  = 1'b1;
                end else if (state_q == StBiasWait) begin
                    if (cnt_q == '0) begin
                        state_d = StChRamp;
                        cnt_d   = ChLoad;
                        ch_d    = mode_q ? mask_q : lowest_bit(mask_q);
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end else if (state_q == StChRamp) begin
                    if (cnt_q == '0) begin
                        if (mode_q || (remaining == '0)) begin
                            state_d = StOn;
                            ch_d    = mask_q;
                            ready_d = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            ch_d  = ch_q | lowest_bit(remaining);
                            cnt_d = ChLoad;
                        end
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
            end
            StShutdown: begin
                if (cnt_q == '0) begin
                    state_d = StOff;
                    bias_d  = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                state_d = StOff;
                cnt_d   = '0;
                bias_d  = 1'b0;
                ch_d    = '0;
                ready_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counter, latched config and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StOff;
            cnt_q   <= '0;
            mask_q  <= '0;
            mode_q  <= 1'b0;
            bias_q  <= 1'b0;
            ch_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            bias_q  <= bias_d;
            ch_q    <= ch_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign bias_en = bias_q;
    assign ch_en   = ch_q;
    assign ready   = ready_q;
    assign busy    = busy_q;
    assign state   = state_q;

endmodule

// File: tb/tb_opamp_bank_seq.sv
// Self-checking bench for opamp_bank_seq: first-edge vector table, timed
// hand sequences, and a randomized run against a timing-based reference model.
module tb_opamp_bank_seq;

    localparam int N_CH = 4;
    localparam int BS   = 64;
    localparam int CS   = 16;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            ena      = 1'b0;
    logic            start    = 1'b0;
    logic            stop     = 1'b0;
    logic            mode     = 1'b0;
    logic [N_CH-1:0] cfg_mask = '0;
    logic            bias_en;
    logic [N_CH-1:0] ch_en;
    logic            ready;
    logic            busy;
    logic [2:0]      state;

    opamp_bank_seq #(
        .N_CH        (N_CH),
        .BIAS_SETTLE (BS),
        .CH_SETTLE   (CS),
        .CNT_W       (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .cfg_mask (cfg_mask),
        .mode     (mode),
        .start    (start),
        .stop     (stop),
        .bias_en  (bias_en),
        .ch_en    (ch_en),
        .ready    (ready),
        .busy     (busy),
        .state    (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    // Reference model: 0 = off, 1 = powering/powered (phase derived from
    // elapsed time since the start edge), 2 = shutting down.
    int          m_phase = 0;
    int          m_k     = 0;
    int          m_s     = 0;
    logic [3:0]  m_mask  = '0;
    logic        m_mode  = 1'b0;
    logic [9:0]  exp_vec = '0;

    typedef struct {
        logic       rst_n;
        logic       ena;
        logic       start;
        logic       stop;
        logic [3:0] mask;
        logic       mode;
        logic [9:0] exp;   // {state, bias_en, ch_en, ready, busy}
    } vec_t;

    vec_t vecs[7];

    function automatic logic [9:0] dut_vec();
        return {state, bias_en, ch_en, ready, busy};
    endfunction

    function automatic int popcount(input logic [3:0] m);
        int c = 0;
        for (int i = 0; i < 4; i++) if (m[i]) c++;
        return c;
    endfunction

    // The lowest `cnt` set bits of m.
    function automatic logic [3:0] first_bits(input logic [3:0] m, input int cnt);
        logic [3:0] r = '0;
        int         c = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i] && c < cnt) begin
                r[i] = 1'b1;
                c++;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got {state,bias,ch,ready,busy}=%b required %b",
                     name, edge_n, act, exp);
        end
    endtask

    // Advance the model by one edge using the inputs present at that edge.
    task automatic model_update();
        int e;
        int t_on;
        if (!rst_n) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (ena && start && !stop && cfg_mask != 4'b0) begin
                    m_phase = 1;
                    m_k     = edge_n;
                    m_mask  = cfg_mask;
                    m_mode  = mode;
                end
                1: if (stop || !ena) begin
                    m_phase = 2;
                    m_s     = edge_n;
                end
                default: if (edge_n - m_s == CS) m_phase = 0;
            endcase
        end
        case (m_phase)
            0: exp_vec = '0;
            2: exp_vec = {3'd4, 1'b1, 4'b0000, 1'b0, 1'b1};
            default: begin
                e    = edge_n - m_k;
                t_on = BS + (m_mode ? CS : popcount(m_mask) * CS);
                if (e < BS)
                    exp_vec = {3'd1, 1'b1, 4'b0000, 1'b0, 1'b1};
                else if (e < t_on)
                    exp_vec = {3'd2, 1'b1,
                               m_mode ? m_mask : first_bits(m_mask, (e - BS) / CS + 1),
                               1'b0, 1'b1};
                else
                    exp_vec = {3'd3, 1'b1, m_mask, 1'b1, 1'b0};
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
        model_update();
        chk("model", dut_vec(), exp_vec);
    endtask

    task automatic run_to(input int k, input int target);
        while (edge_n < k + target) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b0; start = 1'b0; stop = 1'b0; cfg_mask = '0; mode = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int k;
        int s;

        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b1011, 1'b0, {3'd1, 1'b1, 4'b0, 1'b0, 1'b1}};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 10'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 10'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 10'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 10'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b1, {3'd1, 1'b1, 4'b0, 1'b0, 1'b1}};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 10'b0};

        do_reset();
        chk("reset", dut_vec(), 10'b0);

        // First-edge behaviour from OFF.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            rst_n = vecs[i].rst_n; ena = vecs[i].ena; start = vecs[i].start;
            stop = vecs[i].stop; cfg_mask = vecs[i].mask; mode = vecs[i].mode;
            step();
            chk($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
        end

        // Staggered ramp, mask 1011; config changes mid-ramp must not matter.
        do_reset();
        ena = 1'b1; cfg_mask = 4'b1011; mode = 1'b0; start = 1'b1;
        step(); k = edge_n;
        chk("stag_e0", dut_vec(), {3'd1, 1'b1, 4'b0000, 1'b0, 1'b1});
        start = 1'b0;
        run_to(k, 63);  chk("stag_e63", dut_vec(), {3'd1, 1'b1, 4'b0000, 1'b0, 1'b1});
        run_to(k, 64);  chk("stag_e64", dut_vec(), {3'd2, 1'b1, 4'b0001, 1'b0, 1'b1});
        cfg_mask = 4'b0100; mode = 1'b1;
        run_to(k, 79);  chk("stag_e79", dut_vec(), {3'd2, 1'b1, 4'b0001, 1'b0, 1'b1});
        run_to(k, 80);  chk("stag_e80", dut_vec(), {3'd2, 1'b1, 4'b0011, 1'b0, 1'b1});
        run_to(k, 96);  chk("stag_e96", dut_vec(), {3'd2, 1'b1, 4'b1011, 1'b0, 1'b1});
        run_to(k, 111); chk("stag_e111", dut_vec(), {3'd2, 1'b1, 4'b1011, 1'b0, 1'b1});
        run_to(k, 112); chk("stag_on", dut_vec(), {3'd3, 1'b1, 4'b1011, 1'b1, 1'b0});
        step();

        // Stop from ON; start during shutdown is ignored.
        stop = 1'b1;
        step(); s = edge_n;
        chk("stop_s", dut_vec(), {3'd4, 1'b1, 4'b0000, 1'b0, 1'b1});
        stop = 1'b0; start = 1'b1; cfg_mask = 4'b1111;
        run_to(s, 15);  chk("stop_s15", dut_vec(), {3'd4, 1'b1, 4'b0000, 1'b0, 1'b1});
        start = 1'b0;
        run_to(s, 16);  chk("stop_s16", dut_vec(), 10'b0);
        step();         chk("stop_s17", dut_vec(), 10'b0);

        // Simultaneous ramp.
        cfg_mask = 4'b1011; mode = 1'b1; start = 1'b1;
        step(); k = edge_n;
        start = 1'b0;
        run_to(k, 63);  chk("sim_e63", dut_vec(), {3'd1, 1'b1, 4'b0000, 1'b0, 1'b1});
        run_to(k, 64);  chk("sim_e64", dut_vec(), {3'd2, 1'b1, 4'b1011, 1'b0, 1'b1});
        run_to(k, 79);  chk("sim_e79", dut_vec(), {3'd2, 1'b1, 4'b1011, 1'b0, 1'b1});
        run_to(k, 80);  chk("sim_on", dut_vec(), {3'd3, 1'b1, 4'b1011, 1'b1, 1'b0});

        // ena low in ON behaves like stop.
        ena = 1'b0;
        step(); s = edge_n;
        chk("ena_s", dut_vec(), {3'd4, 1'b1, 4'b0000, 1'b0, 1'b1});
        run_to(s, 15);  chk("ena_s15", dut_vec(), {3'd4, 1'b1, 4'b0000, 1'b0, 1'b1});
        run_to(s, 16);  chk("ena_s16", dut_vec(), 10'b0);
        ena = 1'b1;

        // Reset mid-ramp, then start on the first edge out of reset.
        cfg_mask = 4'b1011; mode = 1'b0; start = 1'b1;
        step(); k = edge_n;
        start = 1'b0;
        run_to(k, 69);
        rst_n = 1'b0;
        step();         chk("rst_e70", dut_vec(), 10'b0);
        rst_n = 1'b1; start = 1'b1;
        step();         chk("rst_restart", dut_vec(), {3'd1, 1'b1, 4'b0000, 1'b0, 1'b1});
        start = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0;
        for (int i = 0; i < CS + 2; i++) step();

        // Randomized run against the model.
        for (int i = 0; i < 4000; i++) begin
            rst_n    = 1'($urandom_range(999) != 0);
            ena      = 1'($urandom_range(299) != 0);
            start    = 1'($urandom_range(9) == 0);
            stop     = 1'($urandom_range(149) == 0);
            cfg_mask = 4'($urandom_range(15));
            mode     = 1'($urandom_range(1));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
